cu_sequencer: RTL
=================

Name: cu_sequencer

Overview:
- Control-state sequencer that sits directly upstream of the control-unit decode logic.
- Holds the micro-state counter and drives the 40-bit one-hot CPU_state bus.
- Consumes the COUNTER_LD/COUNTER_INC/COUNTER_CLR strobes that the decode logic produces.
- On COUNTER_LD, maps the instruction opcode (plus ALT mode bit) to the start state of that instruction's micro-routine.

Parameters:
- STATES, 40, number of micro-states; width of CPU_state.
- CW, 6, counter width; must satisfy 2**CW >= STATES.
- OPW, 4, opcode field width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- COUNTER_LD  input  1  load counter with the opcode start state.
- COUNTER_INC  input  1  advance counter by 1.
- COUNTER_CLR  input  1  return counter to 0 (fetch1).
- STALL  input  1  freeze counter for this cycle (memory wait).
- OPCODE  input  OPW  opcode field, sampled only when COUNTER_LD=1. The value is taken from the system bus in the same cycle as the load (DR in fetch3), not from IR.
- ALT  input  1  addressing-mode bit, sampled with OPCODE.
- CPU_state  output  STATES  one-hot state = 1 << count.
- COUNT  output  CW  binary counter value, for debug/bench.
- FETCH  output  1  high when count is in {0,1,2}.
- INSTR_DONE  output  1  registered one-cycle pulse, set the cycle after an accepted clear.

Behaviour:
- Reset: when rst_n=0 at a rising edge, count=0, INSTR_DONE=0.
  - Outputs after reset: CPU_state=40'h1, COUNT=0, FETCH=1.
  - Reset overrides every other input, including mid-routine.
- Register update priority at each edge when rst_n=1:
  - STALL=1: count holds; INSTR_DONE<=0.
  - else COUNTER_CLR=1: count<=0; INSTR_DONE<=1.
  - else COUNTER_LD=1: count<=start(OPCODE,ALT); INSTR_DONE<=0.
  - else COUNTER_INC=1: count<=count+1; wraps to 0 if count==STATES-1; INSTR_DONE<=0.
  - else count==3 (nop1): count<=0 and INSTR_DONE<=1. This auto-return is required because the decode logic asserts no strobe in nop1.
  - else: count holds; INSTR_DONE<=0.
- Simultaneous strobes are resolved by the priority above. Multiple strobes are legal but never expected; the bench checks that priority holds.
- Opcode map (start state):
  - 0 nop → 3
  - 1 mov → 4 (ALT=1 → 5)
  - 2 ldr → 7 (ALT=1 → 9)
  - 3 str → 13 (ALT=1 → 17)
  - 4 cmp → 21
  - 5 b → 22
  - 6 bgt → 23
  - 7 blt → 24
  - 8 beq → 25
  - 9 add → 26
  - 10 sub → 28
  - 11 mul → 30
  - 12 lsr → 32
  - 13 and → 34
  - 14 or → 36
  - 15 mvn → 38
  - ALT is ignored for opcodes other than 1–3.
- Decoding and illegal values:
  - CPU_state is a combinational decode of the registered count, so the decode logic sees the new state in the cycle after the strobe.
  - count>=STATES is unreachable. If it is forced, CPU_state=0 and the next edge clears count to 0 regardless of strobes.
- Latency:
  - Fetch is 3 cycles.
  - A 2-state instruction returns to fetch1 in exactly 2 cycles after the load edge.
  - Branch, cmp and nop take 1 cycle.
- CPU_state is always exactly one-hot while count<STATES.

Test Plan:
- Reset mid-routine: drive count to 27, assert rst_n=0 for 1 edge → COUNT=0, CPU_state=40'h1, FETCH=1, INSTR_DONE=0.
- Fetch plus ALT ldr: INC, INC, then LD with OPCODE=2, ALT=1.
  - Required sequence: COUNT 0→1→2→9.
  - Then INC×3 and CLR: 9→10→11→12→0, with INSTR_DONE=1 for one cycle after the CLR edge.
- Full opcode sweep: for each OPCODE 0–15 with ALT=0 and ALT=1, load from count=2 → COUNT matches the map (e.g. 10→28, 3/ALT→17, 9/ALT→26).
- Priority: CLR+LD+INC together → 0; LD+INC with OPCODE=12 → 32; STALL with CLR → hold.
- Nop auto-return: LD with OPCODE=0 → COUNT=3. The next edge with no strobes → COUNT=0 and INSTR_DONE pulses once.
- Wrap and idle: at count=39, INC → 0. At count=27 with no strobes for 5 cycles → COUNT stays 27 and INSTR_DONE stays 0.

Source files
------------

// File: rtl/cu_sequencer.sv
// Micro-state counter with one-hot CPU_state decode; state updates on the edge after a strobe, decode is combinational.
// STALL freezes the counter for a cycle; there is no other backpressure.
module cu_sequencer #(
    parameter int STATES = 40,
    parameter int CW     = 6,
    parameter int OPW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              COUNTER_LD,
    input  logic              COUNTER_INC,
    input  logic              COUNTER_CLR,
    input  logic              STALL,
    input  logic [OPW-1:0]    OPCODE,
    input  logic              ALT,
    output logic [STATES-1:0] CPU_state,
    output logic [CW-1:0]     COUNT,
    output logic              FETCH,
    output logic              INSTR_DONE
);

    localparam logic [CW-1:0] LAST_STATE = CW'(STATES - 1);
    localparam logic [CW-1:0] NOP1_STATE = CW'(3);

    logic [CW-1:0] count;
    logic          instr_done;

    // Start state of each micro-routine; ALT only selects a variant for mov/ldr/str.
    function automatic logic [CW-1:0] start_state(input logic [OPW-1:0] op, input logic alt);
        logic [CW-1:0] s;
        case (int'(op))
            0:       s = CW'(3);
            1:       s = alt ? CW'(5)  : CW'(4);
            2:       s = alt ? CW'(9)  : CW'(7);
            3:       s = alt ? CW'(17) : CW'(13);
            4:       s = CW'(21);
            5:       s = CW'(22);
            6:       s = CW'(23);
            7:       s = CW'(24);
            8:       s = CW'(25);
            9:       s = CW'(26);
            10:      s = CW'(28);
            11:      s = CW'(30);
            12:      s = CW'(32);
            13:      s = CW'(34);
            14:      s = CW'(36);
            15:      s = CW'(38);
            default: s = CW'(3);
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            instr_done <= 1'b0;
        end else if (int'(count) >= STATES) begin
            // Unreachable in normal operation; recover to fetch1 regardless of strobes.
            count      <= '0;
            instr_done <= 1'b0;
        end else if (STALL) begin
            instr_done <= 1'b0;
        end else if (COUNTER_CLR) begin
            count      <= '0;
            instr_done <= 1'b1;
        end else if (COUNTER_LD) begin
            count      <= start_state(OPCODE, ALT);
            instr_done <= 1'b0;
        end else if (COUNTER_INC) begin
            count      <= (count == LAST_STATE) ? '0 : count + CW'(1);
            instr_done <= 1'b0;
        end else if (count == NOP1_STATE) begin
            // Decode asserts no strobe in nop1, so the sequencer returns to fetch on its own.
            count      <= '0;
            instr_done <= 1'b1;
        end else begin
            instr_done <= 1'b0;
        end
    end

    always_comb begin
        CPU_state = '0;
        if (int'(count) < STATES) begin
            CPU_state = STATES'(1) << count;
        end
    end

    assign COUNT      = count;
    assign FETCH      = (count <= CW'(2));
    assign INSTR_DONE = instr_done;

endmodule
